// File: rtl/io_input_ctrl.sv
// Memory-mapped input responder: synchronises and debounces slide switches and
// active-low keys, latches press events and a wrapping press count for the CPU.
module io_input_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int SW_W       = 10,
  parameter int KEY_W      = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [31:0]      addr,
  input  logic             rd_en,
  input  logic [SW_W-1:0]  sw_in,
  input  logic [KEY_W-1:0] key_in,
  output logic [31:0]      io_read_data,
  output logic             irq
);

  localparam int N  = SW_W + KEY_W;
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [N-1:0] RST_VAL = {{KEY_W{1'b1}}, {SW_W{1'b0}}};

  logic [N-1:0]     raw;
  logic [N-1:0]     meta_q, sync_q;
  logic [N-1:0]     stable_q, stable_d;
  logic [KEY_W-1:0] key_stable_q, key_stable_d, key_lvl;
  logic [KEY_W-1:0] press;
  logic [KEY_W-1:0] armed_q, armed_d;
  logic [KEY_W-1:0] event_q, event_d;
  logic [15:0]      count_q, count_d, inc;
  logic [1:0]       vld_q;
  logic [4:0]       sel;
  logic             rd_clr;
  logic             unused_addr_bits;

  assign raw = {key_in, sw_in};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_deb
    logic [CW-1:0] cnt_q, cnt_d;
    logic          st_q, st_d;

    always_comb begin
      cnt_d = cnt_q;
      st_d  = st_q;
      if (sync_q[gi] == st_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        st_d  = sync_q[gi];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        cnt_q <= '0;
        st_q  <= RST_VAL[gi];
      end else begin
        cnt_q <= cnt_d;
        st_q  <= st_d;
      end
    end

    assign stable_q[gi] = st_q;
    assign stable_d[gi] = st_d;
  end

  assign key_stable_q = stable_q[N-1:SW_W];
  assign key_stable_d = stable_d[N-1:SW_W];
  assign key_lvl      = ~key_stable_q;

  // A key only arms once a genuine post-reset sample shows it released, so a
  // key held through reset cannot produce an event until released and re-pressed.
  assign armed_d = armed_q | ({KEY_W{vld_q[1]}} & sync_q[N-1:SW_W] & key_stable_q);
  assign press   = key_stable_q & ~key_stable_d & armed_q;

  assign sel    = addr[6:2];
  assign rd_clr = rd_en & addr[7] & (sel == 5'd2);

  always_comb begin
    inc = '0;
    for (int i = 0; i < KEY_W; i++) begin
      inc = inc + 16'(press[i]);
    end
  end

  // A press landing on the clearing read wins for its own bit.
  assign event_d = (rd_clr ? '0 : event_q) | press;
  assign count_d = count_q + inc;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_q   <= '0;
      armed_q <= '0;
      event_q <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_d;
      event_q <= event_d;
      count_q <= count_d;
    end
  end

  assign irq = |event_q;

  always_comb begin
    io_read_data = '0;
    if (addr[7]) begin
      case (sel)
        5'd0:    io_read_data = 32'(stable_q[SW_W-1:0]);
        5'd1:    io_read_data = 32'(key_lvl);
        5'd2:    io_read_data = 32'(event_q);
        5'd3:    io_read_data = 32'(count_q);
        default: io_read_data = '0;
      endcase
    end
  end

  assign unused_addr_bits = ^{addr[31:8], addr[1:0]};

endmodule
